gate_unit: RTL and testbench



---
 rtl/gate_pkg.sv | 21 ++
 rtl/gate_reduce.sv | 46 ++++
 rtl/gate_unit.sv | 143 ++++++++++++++
 tb/tb_gate_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate_unit slice: operation encoding, queue depth
// and the legal-operation check.
package gate_pkg;

  localparam int OP_W   = 3;
  localparam int QDEPTH = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } gate_op_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= 3'd5);
  endfunction

endpackage

// File: rtl/gate_reduce.sv
// Combinational reduction of NUM_IN packed operands to one WIDTH-bit result
// by the selected operation; err flags an illegal operation code.
module gate_reduce
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [OP_W-1:0]         op,
  input  logic [NUM_IN*WIDTH-1:0] data,
  output logic [WIDTH-1:0]        result,
  output logic                    err
);

  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] xor_s;

  // Fold all operands into the three base reductions
  always_comb begin
    and_s = data[WIDTH-1:0];
    or_s  = data[WIDTH-1:0];
    xor_s = data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      and_s = and_s & data[k*WIDTH +: WIDTH];
      or_s  = or_s  | data[k*WIDTH +: WIDTH];
      xor_s = xor_s ^ data[k*WIDTH +: WIDTH];
    end
  end

  // Select the requested result; illegal codes give zero with err set
  always_comb begin
    result = {WIDTH{1'b0}};
    err    = !is_legal_op(op);
    case (op)
      OP_AND:  result = and_s;
      OP_OR:   result = or_s;
      OP_XOR:  result = xor_s;
      OP_NAND: result = ~and_s;
      OP_NOR:  result = ~or_s;
      OP_XNOR: result = ~xor_s;
      default: result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/gate_unit.sv
// Registered multi-input logic unit with a 2-entry valid/ready output queue.
// Optional GATE_UNIT_STATS_EN adds saturating accept/error counters.
module gate_unit
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
`ifdef GATE_UNIT_STATS_EN
  ,
  output logic [15:0]             stat_count,
  output logic [15:0]             stat_err
`endif
);

  logic [WIDTH:0]   mem_r [QDEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic             full_r;
  logic             rdy_en_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_err_r;

  logic [1:0]       count_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] red_data_s;
  logic             red_err_s;
  logic             wr_ptr_nxt_s;
  logic             rd_ptr_nxt_s;
  logic             full_nxt_s;
  logic [WIDTH:0]   head_nxt_s;

  gate_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .op     (in_op),
    .data   (in_data),
    .result (red_data_s),
    .err    (red_err_s)
  );

  assign count_s   = full_r ? 2'd2 : ((wr_ptr_r != rd_ptr_r) ? 2'd1 : 2'd0);
  assign in_ready  = rdy_en_r && ((count_s < 2'd2) || out_ready);
  assign out_valid = (count_s != 2'd0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;

  // Next pointers and the entry that will sit at the head after this edge
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    full_nxt_s   = full_r;
    head_nxt_s   = {(WIDTH+1){1'b0}};
    if (push_s) begin
      wr_ptr_nxt_s = ~wr_ptr_r;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = ~rd_ptr_r;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_s && !pop_s) begin
      full_nxt_s = (wr_ptr_nxt_s == rd_ptr_r);
    end else if (pop_s && !push_s) begin
      full_nxt_s = 1'b0;
    end else begin
      full_nxt_s = full_r;
    end
    // A fresh result becomes head when it lands in the slot the read pointer moves to
    if (!full_nxt_s && (wr_ptr_nxt_s == rd_ptr_nxt_s)) begin
      head_nxt_s = {(WIDTH+1){1'b0}};
    end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = {red_err_s, red_data_s};
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Queue storage, pointers and registered head outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= {(WIDTH+1){1'b0}};
      end
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      full_r     <= 1'b0;
      rdy_en_r   <= 1'b0;
      out_data_r <= {WIDTH{1'b0}};
      out_err_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {red_err_s, red_data_s};
      end
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      full_r     <= full_nxt_s;
      rdy_en_r   <= 1'b1;
      out_data_r <= head_nxt_s[WIDTH-1:0];
      out_err_r  <= head_nxt_s[WIDTH];
    end
  end

`ifdef GATE_UNIT_STATS_EN
  logic [15:0] stat_count_r;
  logic [15:0] stat_err_r;

  // Saturating transaction and illegal-op counters, stepped on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count_r <= 16'h0000;
      stat_err_r   <= 16'h0000;
    end else if (push_s) begin
      if (stat_count_r != 16'hFFFF) begin
        stat_count_r <= stat_count_r + 16'h0001;
      end
      if (red_err_s && (stat_err_r != 16'hFFFF)) begin
        stat_err_r <= stat_err_r + 16'h0001;
      end
    end
  end

  assign stat_count = stat_count_r;
  assign stat_err   = stat_err_r;
`endif

endmodule

// File: tb/tb_gate_unit.sv
// Self-checking bench for gate_unit (WIDTH=8, NUM_IN=3): directed tables,
// backpressure/reset sequences and randomized traffic against a queue model.
module tb_gate_unit;

  localparam int W = 8;
  localparam int N = 3;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_op;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_err;
`ifdef GATE_UNIT_STATS_EN
  logic [15:0]    stat_count;
  logic [15:0]    stat_err;
`endif

  int total = 0;
  int bad   = 0;
  logic [W:0] model_q[$];

  gate_unit #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef GATE_UNIT_STATS_EN
    ,
    .stat_count(stat_count),
    .stat_err  (stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     op;
    logic [N*W-1:0] data;
    logic [W-1:0]   exp_data;
    logic           exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: per bit, count how many operands hold a one
  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [N*W-1:0] d);
    logic [W-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int k = 0; k < N; k++) ones += d[k*W + b];
      case (op)
        3'd0: r[b] = (ones == N);
        3'd1: r[b] = (ones > 0);
        3'd2: r[b] = (ones % 2 == 1);
        3'd3: r[b] = !(ones == N);
        3'd4: r[b] = !(ones > 0);
        3'd5: r[b] = !(ones % 2 == 1);
        default: r[b] = 1'b0;
      endcase
    end
    return {(op > 3'd5), r};
  endfunction

  // One clock cycle: drive at negedge, check against model, update on posedge
  task automatic cycle(input logic v, input logic [2:0] op, input logic [N*W-1:0] d,
                       input logic rdy, output logic acc);
    logic rel;
    in_valid = v; in_op = op; in_data = d; out_ready = rdy;
    #1;
    chk("out_valid", out_valid, model_q.size() != 0);
    chk("in_ready", in_ready, (model_q.size() < 2) || rdy);
    if (model_q.size() != 0) begin
      chk("head_data", out_data, model_q[0][W-1:0]);
      chk("head_err", out_err, model_q[0][W]);
    end
    acc = v && in_ready;
    rel = out_valid && rdy;
    @(posedge clk);
    if (rel && model_q.size() != 0) void'(model_q.pop_front());
    if (acc) model_q.push_back(ref_op(op, d));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_op = 3'd0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    @(negedge clk);
  endtask

  vec_t vecs[9];
  logic acc;
  logic [2:0] rop;
  logic [N*W-1:0] rdat;

  initial begin
    vecs[0] = '{3'd0, 24'hFF0FA5, 8'h05, 1'b0};
    vecs[1] = '{3'd1, 24'hFF0FA5, 8'hFF, 1'b0};
    vecs[2] = '{3'd2, 24'hFF0FA5, 8'h55, 1'b0};
    vecs[3] = '{3'd3, 24'hFF0FA5, 8'hFA, 1'b0};
    vecs[4] = '{3'd4, 24'hFF0FA5, 8'h00, 1'b0};
    vecs[5] = '{3'd5, 24'hFF0FA5, 8'hAA, 1'b0};
    vecs[6] = '{3'd6, 24'h123456, 8'h00, 1'b1};
    vecs[7] = '{3'd0, 24'hF0F0F0, 8'hF0, 1'b0};
    vecs[8] = '{3'd7, 24'hFFFFFF, 8'h00, 1'b1};

    // Reset state
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_op = 3'd0; in_data = '0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("pre_edge_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("post_edge_in_ready", in_ready, 1'b1);

    // Directed ops: result appears exactly one cycle after acceptance
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].op, vecs[i].data, 1'b1, acc);
      chk("dir_acc", acc, 1'b1);
      chk("dir_valid", out_valid, 1'b1);
      chk("dir_data", out_data, vecs[i].exp_data);
      chk("dir_err", out_err, vecs[i].exp_err);
    end
    cycle(1'b0, 3'd0, '0, 1'b1, acc);

    // Backpressure: two accepted, third refused, then drain in order
    cycle(1'b1, 3'd0, 24'hFF0FFF, 1'b0, acc); chk("bp_acc1", acc, 1'b1);
    cycle(1'b1, 3'd1, 24'h000110, 1'b0, acc); chk("bp_acc2", acc, 1'b1);
    cycle(1'b1, 3'd2, 24'h00FFFF, 1'b0, acc); chk("bp_acc3", acc, 1'b0);
    chk("bp_hold", out_data, 8'h0F);
    cycle(1'b1, 3'd2, 24'h00FFFF, 1'b0, acc); chk("bp_acc3b", acc, 1'b0);
    chk("bp_hold2", out_data, 8'h0F);
    cycle(1'b1, 3'd2, 24'h00FFFF, 1'b1, acc); chk("bp_pass", acc, 1'b1);
    chk("bp_d1", out_data, 8'h11);
    cycle(1'b0, 3'd0, '0, 1'b1, acc);
    chk("bp_d2", out_data, 8'h00);
    chk("bp_d2_valid", out_valid, 1'b1);
    cycle(1'b0, 3'd0, '0, 1'b1, acc);
    chk("bp_empty", out_valid, 1'b0);

    // Asynchronous reset mid-cycle while full
    cycle(1'b1, 3'd1, 24'h0000AA, 1'b0, acc);
    cycle(1'b1, 3'd1, 24'h000055, 1'b0, acc);
    chk("full_before_rst", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 8'h00);
    chk("arst_in_ready", in_ready, 1'b0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_ready_after", in_ready, 1'b1);
    chk("arst_still_empty", out_valid, 1'b0);

    // Continuous streaming: one accept per cycle
    for (int i = 0; i < 100; i++) begin
      rop  = 3'($urandom_range(0, 7));
      rdat = N*W'($urandom);
      cycle(1'b1, rop, rdat, 1'b1, acc);
      chk("stream_acc", acc, 1'b1);
    end
    // Random valid/ready mix
    for (int i = 0; i < 200; i++) begin
      rop  = 3'($urandom_range(0, 7));
      rdat = N*W'($urandom);
      cycle(1'($urandom_range(0, 1)), rop, rdat, 1'($urandom_range(0, 1)), acc);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, '0, 1'b1, acc);
    chk("final_empty", out_valid, 1'b0);

`ifdef GATE_UNIT_STATS_EN
    do_reset();
    chk("stat_cnt_rst", stat_count, 16'd0);
    chk("stat_err_rst", stat_err, 16'd0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, (i < 5) ? 3'(i) : 3'(6 + i - 5), 24'h5A5A5A, 1'b1, acc);
    end
    chk("stat_count", stat_count, 16'd7);
    chk("stat_err", stat_err, 16'd2);
    do_reset();
    chk("stat_cnt_clr", stat_count, 16'd0);
    chk("stat_err_clr", stat_err, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
